// File: rtl/reg_transfer_arbiter_if.sv
// Bus-side signal bundle for the register transfer arbiter.
// Handshake: req is a level request that the arbiter samples only while idle;
// the winner's grant bit stays high until the transfer leaves DONE. A
// requester may drop req at any point after its grant rises without
// aborting the transfer, and a req still held when the arbiter returns to
// idle is arbitrated again.
interface reg_transfer_arbiter_if #(
   parameter int NrOfRegs       = 8,
   parameter int NrOfRequesters = 4,
   parameter int AddrBits       = 3
);
   logic [NrOfRequesters-1:0]          req;
   logic [NrOfRequesters*AddrBits-1:0] src_sel;
   logic [NrOfRequesters*AddrBits-1:0] dst_sel;
   logic [NrOfRequesters-1:0]          grant;
   logic                               busy;
   logic                               done;
   logic                               err;
   logic [NrOfRegs-1:0]                reg_oe_n;
   logic [NrOfRegs-1:0]                reg_load;

   modport master (
      output req, src_sel, dst_sel,
      input  grant, busy, done, err, reg_oe_n, reg_load
   );

   modport slave (
      input  req, src_sel, dst_sel,
      output grant, busy, done, err, reg_oe_n, reg_load
   );
endinterface

// File: rtl/reg_transfer_arbiter.sv
// Round-robin arbiter and sequencer for register-to-register moves over the
// shared tristate data bus. A transfer is: drive the source onto the bus for
// one tick so it settles, keep driving while the destination loads, then
// report completion. At most one register ever drives the bus.
module reg_transfer_arbiter #(
   parameter int NrOfRegs       = 8,
   parameter int NrOfRequesters = 4,
   parameter int AddrBits       = 3
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Tick,
   reg_transfer_arbiter_if.slave bus,
   output logic [1:0]            state_dbg
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int PtrBits = (NrOfRequesters > 1) ? $clog2(NrOfRequesters) : 1;
   localparam int SelSpan = 1 << AddrBits;

   // Bit i is set when register index i exists on the bus.
   function automatic logic [SelSpan-1:0] in_range_mask();
      logic [SelSpan-1:0] m;
      m = '0;
      for (int i = 0; i < SelSpan; i++) m[i] = (i < NrOfRegs);
      return m;
   endfunction

   localparam logic [SelSpan-1:0] InRange = in_range_mask();

   state_t                    state;
   state_t                    state_nx;
   logic [PtrBits-1:0]        ptr;
   logic [NrOfRequesters-1:0] grant_q;
   logic [AddrBits-1:0]       src_q;
   logic [AddrBits-1:0]       dst_q;

   logic                      win_found;
   logic [PtrBits-1:0]        win_idx;
   logic [PtrBits-1:0]        cand_idx;
   int                        cand;
   logic [AddrBits-1:0]       win_src;
   logic [AddrBits-1:0]       win_dst;

   logic                      range_err;
   logic                      xfer_ok;
   logic [NrOfRegs-1:0]       oe_n_d;
   logic [NrOfRegs-1:0]       load_d;

   // Round-robin search starting one past the last winner, plus the winner's selects.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      win_src   = '0;
      win_dst   = '0;
      for (int k = 1; k <= NrOfRequesters; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NrOfRequesters) cand = cand - NrOfRequesters;
         cand_idx = PtrBits'(cand);
         if (!win_found && bus.req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
      for (int i = 0; i < NrOfRequesters; i++) begin
         if (win_idx == PtrBits'(i)) begin
            win_src = bus.src_sel[i*AddrBits +: AddrBits];
            win_dst = bus.dst_sel[i*AddrBits +: AddrBits];
         end
      end
   end

   // A transfer touches the bus only when both indices exist and differ.
   assign range_err = !(InRange[src_q] && InRange[dst_q]);
   assign xfer_ok   = !range_err && (src_q != dst_q);

   // State register; advances only on ticked edges.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else if (Tick) state <= state_nx;
   end

   // Arbitration results: pointer, grant and latched indices.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ptr     <= PtrBits'(NrOfRequesters - 1);
         grant_q <= '0;
         src_q   <= '0;
         dst_q   <= '0;
      end else if (Tick) begin
         if (state == ST_IDLE && win_found) begin
            ptr     <= win_idx;
            grant_q <= NrOfRequesters'(1) << win_idx;
            src_q   <= win_src;
            dst_q   <= win_dst;
         end else if (state == ST_DONE) begin
            grant_q <= '0;
         end
      end
   end

   // Next state and bus-control decode from registered state and latched indices.
   always_comb begin
      state_nx = state;
      oe_n_d   = '1;
      load_d   = '0;
      unique case (state)
         ST_IDLE:  if (win_found) state_nx = ST_DRIVE;
         ST_DRIVE: state_nx = xfer_ok ? ST_LOAD : ST_DONE;
         ST_LOAD:  state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
      endcase
      for (int r = 0; r < NrOfRegs; r++) begin
         if ((state == ST_DRIVE || state == ST_LOAD) && xfer_ok && src_q == AddrBits'(r))
            oe_n_d[r] = 1'b0;
         if (state == ST_LOAD && xfer_ok && dst_q == AddrBits'(r))
            load_d[r] = 1'b1;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.busy     = (state != ST_IDLE);
   assign bus.done     = (state == ST_DONE);
   assign bus.err      = (state == ST_DONE) && range_err;
   assign bus.reg_oe_n = oe_n_d;
   assign bus.reg_load = load_d;
   assign state_dbg    = state;
endmodule

// File: doc/reg_transfer_arbiter.md
# reg_transfer_arbiter

Sequences register-to-register transfers over the CPU's shared tristate data bus. Arbitrates between up to NrOfRequesters transfer requesters with round-robin priority, and drives per-register output-disable and load-enable lines for the bank of tick-gated, preset-capable registers. Guarantees that at most one register drives the bus at any time. It sits between the control unit (and DMA-style requesters) and the memory register bank.

## Interface
- NrOfRegs, 8: number of registers on the shared bus.
- NrOfRequesters, 4: number of transfer requesters.
- AddrBits, 3: register index width; NrOfRegs ≤ 2^AddrBits.
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; forces the reset state below.
- Tick  in  1  clock-enable; the FSM, grant and pointer advance only on edges where Tick=1.
- req  in  NrOfRequesters  level request; bit i is requester i.
- src_sel  in  NrOfRequesters*AddrBits  packed source index; slice i belongs to requester i.
- dst_sel  in  NrOfRequesters*AddrBits  packed destination index.
- grant  out  NrOfRequesters  one-hot grant, held for the whole transfer.
- busy  out  1  high in any state except IDLE.
- done  out  1  high during DONE state only.
- err  out  1  high during DONE if the latched src or dst index ≥ NrOfRegs.
- reg_oe_n  out  NrOfRegs  per-register output disable; 1 = high-impedance.
- reg_load  out  NrOfRegs  per-register ClockEnable; one-hot or zero.

## Operation
- States: IDLE, DRIVE, LOAD, DONE. All transitions occur only on Clock edges with Tick=1.
- IDLE → DRIVE:
  - Taken when any req bit is set.
  - The winner is the first set bit at or above (ptr+1) mod NrOfRequesters, wrapping around.
  - Registers grant and latches the winner's src/dst slices.
  - Sets ptr to the winner.
- DRIVE:
  - reg_oe_n[src]=0; all others stay 1.
  - This state exists for one tick so the bus can settle.
  - Advances to LOAD.
- LOAD:
  - reg_oe_n[src]=0 and reg_load[dst]=1.
  - The destination captures the bus on the edge leaving LOAD.
  - Advances to DONE.
- DONE:
  - All reg_oe_n=1, reg_load=0, done=1, grant held.
  - Advances to IDLE, where grant clears.
- Special cases:
  - **src==dst:** treated as a no-op. The FSM goes DRIVE→DONE directly; no reg_oe_n or reg_load assertion occurs in DRIVE.
  - **Out-of-range index:** oe/load are never asserted for the transfer. The FSM goes DRIVE→DONE with err=1.
- req is sampled only in IDLE. Deasserting req mid-transfer does not abort the transfer; a held req is re-arbitrated in IDLE.
- Invariants:
  - Popcount(~reg_oe_n) ≤ 1 at all times.
  - Popcount(reg_load) ≤ 1 at all times.
  - reg_load is never high while the same register's reg_oe_n is 0 (src≠dst enforced).
- All outputs are decoded from registered state and latched indices; no combinational path from req to reg_oe_n or reg_load.
- Reset state:
  - IDLE, ptr = NrOfRequesters-1, so requester 0 has highest priority first.
  - grant=0, busy=0, done=0, err=0, reg_oe_n all 1, reg_load all 0.
  - Reset mid-transfer immediately releases the bus and load lines with no partial load. Outputs are combinational from reset-forced registers.

## Timing
- Normal transfer: 4 ticks from the arbitration edge to return to IDLE.
  - Arbitration edge E0 → DRIVE.
  - E1 → LOAD.
  - Destination captures at E2; E2 → DONE.
  - E3 → IDLE.
- Back-to-back throughput: one transfer per 4 ticks. The next arbitration occurs at the edge after re-entering IDLE.
- No-op or error transfer: 3 ticks (IDLE→DRIVE→DONE→IDLE).
- With Tick=0, all outputs hold their values indefinitely, including an asserted reg_load. This is safe because the destination register also gates on Tick.
- done and err each last exactly one tick interval.

## Test plan
- **Reset values:** Reset pulsed mid-LOAD (src=2, dst=5) → reg_oe_n=8'hFF and reg_load=0 immediately; register 5 is unchanged; busy=0.
- **Single transfer:** Tick=1 continuously, req=4'b0001, src=1, dst=6.
  - reg_oe_n=8'hFD for 2 cycles.
  - reg_load=8'h40 in the second of those cycles.
  - done one cycle later; busy low after 4 cycles total.
- **Round-robin fairness:** req=4'b1111 held → grant order 0001, 0010, 0100, 1000, 0001, with 4-cycle spacing.
- **No-op and error:**
  - src=dst=3 → 3-tick transfer, reg_oe_n stays FF, reg_load stays 0, err=0.
  - NrOfRegs=6 with dst=7 → err=1 in DONE, no oe/load asserted.
- **Tick gating and req drop:**
  - Tick asserted every 3rd cycle → state advances only on tick edges; the transfer spans 12 Clock cycles.
  - req dropped in DRIVE → the transfer still completes with done=1.
- **Contention invariant:** randomized req/src/dst for 10k cycles → ≤1 zero in reg_oe_n every cycle, ≤1 bit in reg_load every cycle, and no overlap between reg_load and ~reg_oe_n.
